// File: rtl/ans_mode_sequencer.sv
// Host-side sequencer for the ANS core: accepts one load/encode/decode/clear
// request at a time, holds core_cmd for the whole operation and drains output.
module ans_mode_sequencer #(
  parameter int unsigned SYM_WIDTH = 4,
  parameter int unsigned SYM_COUNT = 16,
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_op,
  input  logic [LEN_WIDTH-1:0] req_len,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [SYM_WIDTH-1:0] h_in,
  input  logic                 h_in_vld,
  output logic                 h_in_rdy,
  output logic [SYM_WIDTH-1:0] h_out,
  output logic                 h_out_vld,
  input  logic                 h_out_rdy,
  output logic [1:0]           core_cmd,
  output logic [SYM_WIDTH-1:0] core_in,
  output logic                 core_in_vld,
  input  logic                 core_in_rdy,
  input  logic [SYM_WIDTH-1:0] core_out,
  input  logic                 core_out_vld,
  output logic                 core_out_rdy,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 table_loaded,
  output logic [LEN_WIDTH-1:0] out_cnt
);

  localparam int unsigned BEAT_W = (SYM_COUNT > 1) ? $clog2(SYM_COUNT) : 1;
  localparam int unsigned IDLE_W = 4;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_ENC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ENC, S_DEC, S_DRAIN, S_DONE
  } state_t;

  state_t               state, state_d;
  logic [LEN_WIDTH-1:0] remaining, remaining_d;
  logic [BEAT_W-1:0]    beat_cnt, beat_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt, idle_cnt_d;
  logic [LEN_WIDTH-1:0] out_cnt_d;
  logic [1:0]           core_cmd_d;
  logic                 table_loaded_d, req_rdy_d, busy_d, done_d, err_d;
  logic                 in_active, out_active, in_hs, out_hs;

  // Data pass-through is combinational; gating depends only on state.
  always_comb begin
    in_active    = (state == S_LOAD) ||
                   (((state == S_ENC) || (state == S_DEC)) && (remaining != '0));
    out_active   = (state == S_ENC) || (state == S_DEC) || (state == S_DRAIN);
    core_in      = h_in;
    core_in_vld  = in_active && h_in_vld;
    h_in_rdy     = in_active && core_in_rdy;
    h_out        = out_active ? core_out : '0;
    h_out_vld    = out_active && core_out_vld;
    core_out_rdy = out_active && h_out_rdy;
    in_hs        = core_in_vld && core_in_rdy;
    out_hs       = h_out_vld && h_out_rdy;
  end

  always_comb begin
    state_d        = state;
    remaining_d    = remaining;
    beat_cnt_d     = beat_cnt;
    idle_cnt_d     = idle_cnt;
    table_loaded_d = table_loaded;
    out_cnt_d      = out_cnt;
    err_d          = 1'b0;
    done_d         = 1'b0;
    busy_d         = 1'b0;
    req_rdy_d      = 1'b0;
    core_cmd_d     = OP_CLR;

    if (out_hs && (out_cnt != '1)) begin
      out_cnt_d = out_cnt + LEN_WIDTH'(1);
    end

    case (state)
      S_IDLE: begin
        if (req_vld) begin
          case (req_op)
            OP_LOAD: begin
              state_d        = S_LOAD;
              table_loaded_d = 1'b0;
              beat_cnt_d     = '0;
            end
            OP_ENC, OP_DEC: begin
              if (table_loaded && (req_len != '0)) begin
                state_d     = (req_op == OP_ENC) ? S_ENC : S_DEC;
                remaining_d = req_len;
                out_cnt_d   = '0;
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin
              table_loaded_d = 1'b0;
              state_d        = S_DONE;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          beat_cnt_d = beat_cnt + BEAT_W'(1);
          if (beat_cnt == BEAT_W'(SYM_COUNT - 1)) begin
            table_loaded_d = 1'b1;
            state_d        = S_DONE;
          end
        end
      end
      S_ENC, S_DEC: begin
        if (in_hs) begin
          remaining_d = remaining - LEN_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) begin
            state_d    = S_DRAIN;
            idle_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        // Only an unbroken run of idle core-output cycles ends the drain.
        if (core_out_vld) begin
          idle_cnt_d = '0;
        end else if (idle_cnt == IDLE_W'(DRAIN_CYC - 1)) begin
          state_d = S_DONE;
        end else begin
          idle_cnt_d = idle_cnt + IDLE_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
    req_rdy_d = (state_d == S_IDLE);

    // DRAIN keeps the cmd of the op it drains; IDLE/DONE force the 00 gap.
    case (state_d)
      S_LOAD:  core_cmd_d = OP_LOAD;
      S_ENC:   core_cmd_d = OP_ENC;
      S_DEC:   core_cmd_d = OP_DEC;
      S_DRAIN: core_cmd_d = core_cmd;
      default: core_cmd_d = OP_CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      beat_cnt     <= '0;
      idle_cnt     <= '0;
      table_loaded <= 1'b0;
      out_cnt      <= '0;
      core_cmd     <= OP_CLR;
      req_rdy      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_d;
      remaining    <= remaining_d;
      beat_cnt     <= beat_cnt_d;
      idle_cnt     <= idle_cnt_d;
      table_loaded <= table_loaded_d;
      out_cnt      <= out_cnt_d;
      core_cmd     <= core_cmd_d;
      req_rdy      <= req_rdy_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_ans_mode_sequencer.sv
// Directed bench for ans_mode_sequencer: ordering rules, load, encode with
// output stall and drain timing, clear, back-to-back requests, mid-op reset.
module tb_ans_mode_sequencer;

  localparam int unsigned SW = 4;
  localparam int unsigned SC = 16;
  localparam int unsigned LW = 8;
  localparam int unsigned DC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_op;
  logic [LW-1:0] req_len;
  logic          req_vld;
  logic          req_rdy;
  logic [SW-1:0] h_in;
  logic          h_in_vld;
  logic          h_in_rdy;
  logic [SW-1:0] h_out;
  logic          h_out_vld;
  logic          h_out_rdy;
  logic [1:0]    core_cmd;
  logic [SW-1:0] core_in;
  logic          core_in_vld;
  logic          core_in_rdy;
  logic [SW-1:0] core_out;
  logic          core_out_vld;
  logic          core_out_rdy;
  logic          busy;
  logic          done;
  logic          err;
  logic          table_loaded;
  logic [LW-1:0] out_cnt;

  int checks = 0;
  int errors = 0;
  int in_hs  = 0;
  int out_hs = 0;
  int in0, out0;

  ans_mode_sequencer #(
    .SYM_WIDTH(SW), .SYM_COUNT(SC), .LEN_WIDTH(LW), .DRAIN_CYC(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_op(req_op), .req_len(req_len), .req_vld(req_vld), .req_rdy(req_rdy),
    .h_in(h_in), .h_in_vld(h_in_vld), .h_in_rdy(h_in_rdy),
    .h_out(h_out), .h_out_vld(h_out_vld), .h_out_rdy(h_out_rdy),
    .core_cmd(core_cmd), .core_in(core_in), .core_in_vld(core_in_vld),
    .core_in_rdy(core_in_rdy), .core_out(core_out), .core_out_vld(core_out_vld),
    .core_out_rdy(core_out_rdy), .busy(busy), .done(done), .err(err),
    .table_loaded(table_loaded), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_in_vld && core_in_rdy) in_hs++;
    if (h_out_vld && h_out_rdy) out_hs++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Per-cycle core output script for the encode test (ENC x5, then DRAIN x5).
  int ov   [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int od   [10] = '{0, 3, 5, 5, 5, 9, 0, 0, 0, 0};
  int ordy [10] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    rst_n = 1'b1;
    req_op = 2'b00; req_len = '0; req_vld = 1'b0;
    h_in = 4'hA; h_in_vld = 1'b1; h_out_rdy = 1'b1;
    core_in_rdy = 1'b1; core_out = 4'hA; core_out_vld = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state, with live inputs that must not leak through
    step;
    check("rst_cmd", 32'(core_cmd), 32'd0);
    check("rst_tl", 32'(table_loaded), 32'd0);
    check("rst_cnt", 32'(out_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(req_rdy), 32'd1);
    check("rst_hov", 32'(h_out_vld), 32'd0);
    check("rst_ho", 32'(h_out), 32'd0);
    check("rst_civ", 32'(core_in_vld), 32'd0);
    check("rst_hir", 32'(h_in_rdy), 32'd0);
    check("rst_cor", 32'(core_out_rdy), 32'd0);
    h_in_vld = 1'b0; core_out_vld = 1'b0; h_out_rdy = 1'b0; core_out = '0;
    rst_n = 1'b1;
    step;

    // ENC before any table load is rejected
    req_op = 2'b01; req_len = 8'd3; req_vld = 1'b1;
    step;
    req_vld = 1'b0;
    check("enc_noload_err", 32'(err), 32'd1);
    check("enc_noload_cmd", 32'(core_cmd), 32'd0);
    check("enc_noload_busy", 32'(busy), 32'd0);
    check("enc_noload_tl", 32'(table_loaded), 32'd0);
    step;
    check("enc_noload_err_pulse", 32'(err), 32'd0);

    // Full table load
    in0 = in_hs;
    req_op = 2'b11; req_vld = 1'b1;
    step;
    req_vld = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    check("load_rdy", 32'(req_rdy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      h_in = SW'(i + 1); h_in_vld = 1'b1;
      #1;
      check("load_cmd", 32'(core_cmd), 32'd3);
      check("load_data", 32'(core_in), 32'((i + 1) % 16));
      check("load_tl", 32'(table_loaded), 32'd0);
      step;
    end
    h_in_vld = 1'b0;
    check("load_done", 32'(done), 32'd1);
    check("load_done_cmd", 32'(core_cmd), 32'd0);
    check("load_tl_set", 32'(table_loaded), 32'd1);
    check("load_beats", 32'(in_hs - in0), 32'd16);
    step;
    check("load_done_pulse", 32'(done), 32'd0);
    check("load_idle_rdy", 32'(req_rdy), 32'd1);

    // ENC len 5 with 3 output beats, host stall, then drain
    in0 = in_hs; out0 = out_hs;
    req_op = 2'b01; req_len = 8'd5; req_vld = 1'b1; h_in = 4'h7; h_in_vld = 1'b1;
    step;
    req_vld = 1'b0;
    check("enc_cnt_clr", 32'(out_cnt), 32'd0);
    for (int k = 0; k < 10; k++) begin
      core_out_vld = ov[k][0]; core_out = SW'(od[k]); h_out_rdy = ordy[k][0];
      #1;
      check("enc_cmd", 32'(core_cmd), 32'd1);
      check("enc_hov", 32'(h_out_vld), 32'(ov[k]));
      check("enc_ho", 32'(h_out), 32'(od[k]));
      check("enc_cor", 32'(core_out_rdy), 32'(ordy[k]));
      check("enc_hir", 32'(h_in_rdy), (k < 5) ? 32'd1 : 32'd0);
      check("enc_early_done", 32'(done), 32'd0);
      step;
    end
    h_in_vld = 1'b0; core_out_vld = 1'b0; h_out_rdy = 1'b0; core_out = '0;
    check("enc_done", 32'(done), 32'd1);
    check("enc_done_cmd", 32'(core_cmd), 32'd0);
    check("enc_out_cnt", 32'(out_cnt), 32'd3);
    check("enc_in_beats", 32'(in_hs - in0), 32'd5);
    check("enc_out_beats", 32'(out_hs - out0), 32'd3);
    step;

    // DEC with zero length is rejected
    req_op = 2'b10; req_len = 8'd0; req_vld = 1'b1;
    step;
    req_vld = 1'b0;
    check("dec0_err", 32'(err), 32'd1);
    check("dec0_busy", 32'(busy), 32'd0);
    check("dec0_cmd", 32'(core_cmd), 32'd0);
    step;

    // Clear table
    req_op = 2'b00; req_vld = 1'b1;
    step;
    req_vld = 1'b0;
    check("clr_done", 32'(done), 32'd1);
    check("clr_tl", 32'(table_loaded), 32'd0);
    check("clr_err", 32'(err), 32'd0);
    step;
    check("clr_done_pulse", 32'(done), 32'd0);

    // DEC after clear is rejected
    req_op = 2'b10; req_len = 8'd2; req_vld = 1'b1;
    step;
    req_vld = 1'b0;
    check("dec_clr_err", 32'(err), 32'd1);
    check("dec_clr_cmd", 32'(core_cmd), 32'd0);
    step;

    // Back-to-back: LOAD then ENC with req_vld held high
    req_op = 2'b11; req_vld = 1'b1; h_in_vld = 1'b1; h_in = 4'h2;
    step;
    req_op = 2'b01; req_len = 8'd4;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("b2b_load_cmd", 32'(core_cmd), 32'd3);
      check("b2b_load_rdy", 32'(req_rdy), 32'd0);
      step;
    end
    check("b2b_done_cmd", 32'(core_cmd), 32'd0);
    check("b2b_done_rdy", 32'(req_rdy), 32'd0);
    check("b2b_done", 32'(done), 32'd1);
    step;
    check("b2b_idle_cmd", 32'(core_cmd), 32'd0);
    check("b2b_idle_rdy", 32'(req_rdy), 32'd1);
    check("b2b_idle_tl", 32'(table_loaded), 32'd1);
    step;
    req_vld = 1'b0;
    check("b2b_enc_cmd", 32'(core_cmd), 32'd1);
    check("b2b_enc_rdy", 32'(req_rdy), 32'd0);
    step;
    step;

    // Reset with 2 beats remaining
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd", 32'(core_cmd), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tl", 32'(table_loaded), 32'd0);
    check("mid_rst_civ", 32'(core_in_vld), 32'd0);
    check("mid_rst_rdy", 32'(req_rdy), 32'd1);
    step;
    rst_n = 1'b1; h_in_vld = 1'b0;
    step;
    req_op = 2'b01; req_len = 8'd2; req_vld = 1'b1;
    step;
    req_vld = 1'b0;
    check("post_rst_err", 32'(err), 32'd1);
    check("post_rst_cmd", 32'(core_cmd), 32'd0);
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
